pte_fetch_unit: RTL
===================

# pte_fetch_unit

Memory-side responder for the page-table walker's PTE read port. Accepts the walker's level-held read request (`ren`/`pa`), answers with a 64-bit PTE and a `stall` flag, and serves hits from a small fully-associative PTE buffer. Misses become a single read on a valid/ready memory request channel, with a separate read-return channel. Sits between the walker and the data-cache/memory arbiter.

## Interface
- `ADDR_WIDTH`, 64, physical address and PTE width
- `ENTRIES`, 4, PTE buffer entries (power of two, ≥2)
- `clk` in 1, clock
- `rstn` in 1, reset; one clock; reset is synchronous and active-low
- `ren` in 1, walker read request, level-held until accepted
- `pa` in ADDR_WIDTH, PTE physical address, 8-byte aligned, stable while `ren`=1 and `stall`=1
- `flush` in 1, invalidate all buffer entries (sfence.vma)
- `stall` out 1, 1 = response not ready this cycle
- `pte` out ADDR_WIDTH, returned PTE, valid when `ren`=1 and `stall`=0
- `mem_req` out 1, memory read request valid
- `mem_addr` out ADDR_WIDTH, memory read address (= captured `pa`)
- `mem_ready` in 1, request accepted when `mem_req` and `mem_ready` are both 1
- `mem_rvalid` in 1, read data return strobe
- `mem_rdata` in ADDR_WIDTH, returned PTE
- `mem_rerr` in 1, access fault, qualified by `mem_rvalid`

## Operation
- Handshake: each cycle with `ren`=1 and `stall`=0 completes one request. The next `ren`=1 cycle is a new request, even when `pa` is unchanged.
- `stall` is combinational: `ren & ~hit` in IDLE; 0 only in RESP. It is 1 in the first `ren` cycle on a miss. Hit lookup and hit data are combinational from `pa`.
- FSM states:
  - IDLE: on `ren & ~hit`, capture `pa` into `addr_q` and go to REQ.
  - REQ: `mem_req`=1, `mem_addr`=`addr_q`. On `mem_ready`, go to WAIT.
  - WAIT: on `mem_rvalid`, capture `data_q` (`rdata`, or 0 if `mem_rerr`), then go to RESP if `ren` is still 1, else IDLE.
  - RESP: `stall`=0, `pte`=`data_q`. Unconditionally go to IDLE.
- Fault: `mem_rerr` returns PTE 0 (V=0), so the walker terminates the walk. Faulted data is never filled.
- Fill: on `mem_rvalid` with `~mem_rerr`, `rdata[0]`=1 and no drop flag set, write tag `addr_q[ADDR_WIDTH-1:3]` and data at the round-robin pointer, then increment the pointer (wraps at `ENTRIES`-1). Invalid PTEs are not buffered.
- Tag compare uses `pa[ADDR_WIDTH-1:3]`; `pa[2:0]` is ignored.
- `flush`:
  - Clears all entry valid bits next cycle.
  - During REQ/WAIT, sets the drop flag so the in-flight fill is suppressed.
  - Forces miss for lookups in the same cycle.
  - Does not cancel the memory transaction; the response is still returned.
- `ren` deasserted mid-miss: the transaction drains (REQ→WAIT→rvalid), fills if allowed, then returns to IDLE without RESP.
- Only one outstanding memory read. A `mem_rvalid` outside WAIT is ignored.

## Timing
- Reset values:
  - `stall`=0, `pte`=0, `mem_req`=0, `mem_addr`=0.
  - All entries invalid, round-robin pointer 0, drop flag 0, FSM IDLE.
- Reset mid-transaction abandons it; later stray `mem_rvalid` is ignored.
- Hit: 0-cycle latency, with `stall`=0 in the same cycle `ren` is sampled.
- Miss, with `ren` rising at cycle T:
  - `mem_req` at T+1.
  - If `mem_ready` at T+1 and `mem_rvalid` at T+1+k (k≥1), the response (`stall`=0) comes at T+2+k.
  - `mem_req` stays high across `mem_ready`=0 cycles.
- `pte` outside response cycles is don't-care but driven to 0.

## Configuration
- `PTE_BUF_EN` defined: buffer present as described.
- `PTE_BUF_EN` undefined:
  - No buffer, hit is tied to 0, and every request takes the miss path.
  - `flush` is ignored, with no fill logic or round-robin pointer.
  - Port list is unchanged.

## Structure
- `PageStruct` package adds:
  - `pte_fetch_state_t` enum (IDLE, REQ, WAIT, RESP; one-hot, 4 bits).
  - `PteBufEntry` struct (valid, tag, data).
  - `PTE_V_BIT`=0 constant.
- One sub-module, `pte_buffer`: combinational lookup (hit, data) plus a registered fill/flush with the round-robin pointer. It is instantiated only under `PTE_BUF_EN`.

## Test plan
- Reset, then `ren`=1 with `pa`=0x8000_1000 and the buffer empty → `stall`=1 at T, `mem_req`/`mem_addr`=0x8000_1000 at T+1. With `mem_ready`=1, and `rvalid` at T+3 carrying `rdata`=0x2000_0C01 → `stall`=0 and `pte`=0x2000_0C01 at T+4.
- Repeat `ren` with the same `pa` → `stall`=0 and `pte`=0x2000_0C01 in the same cycle, `mem_req` stays 0.
- `mem_rerr`=1 on a miss → response `pte`=0. A repeat request misses again.
- Fill 5 distinct valid PTEs with `ENTRIES`=4 → the first address misses again and the other three hit.
- Assert `flush` during WAIT → the response is still delivered, but the same `pa` then misses. Also `flush` in IDLE followed by a previously hit address → miss.
- Deassert `ren` while in REQ with `mem_ready`=0 for 3 cycles → the drain completes, no `stall`=0 response, FSM returns to IDLE, and the next request proceeds normally.

Source files
------------

// File: rtl/pte_fetch_unit_pkg.sv
// Shared types for the PTE fetch unit: FSM state encoding and PTE buffer entry layout.
package PageStruct;

    localparam int PTE_WIDTH     = 64;
    localparam int PTE_TAG_WIDTH = PTE_WIDTH - 3;
    localparam int PTE_V_BIT     = 0;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        REQ  = 4'b0010,
        WAIT = 4'b0100,
        RESP = 4'b1000
    } pte_fetch_state_t;

    typedef struct packed {
        logic                     valid;
        logic [PTE_TAG_WIDTH-1:0] tag;
        logic [PTE_WIDTH-1:0]     data;
    } PteBufEntry;

endpackage

// File: rtl/pte_fetch_unit_buffer.sv
// Small fully-associative PTE buffer: combinational tag lookup, registered
// round-robin fill and whole-buffer flush.
module pte_buffer
    import PageStruct::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic [PTE_TAG_WIDTH-1:0] lookup_tag,
    output logic                     hit,
    output logic [PTE_WIDTH-1:0]     hit_data,
    input  logic                     fill_en,
    input  logic [PTE_TAG_WIDTH-1:0] fill_tag,
    input  logic [PTE_WIDTH-1:0]     fill_data
);

    localparam int PTR_W = $clog2(ENTRIES);

    PteBufEntry       entries [ENTRIES];
    logic [PTR_W-1:0] rr_ptr;

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entries[i].valid && (entries[i].tag == lookup_tag)) begin
                hit      = 1'b1;
                hit_data = entries[i].data;
            end
        end
    end

    // ENTRIES is a power of two, so the pointer wraps by plain overflow.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= '0;
            end
            rr_ptr <= '0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else if (fill_en) begin
            entries[rr_ptr] <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
            rr_ptr          <= rr_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pte_fetch_unit.sv
// PTE read responder for the page-table walker; misses go out on a valid/ready
// memory channel. Define PTE_BUF_EN to include the PTE buffer (hits + flush).
//
// state | meaning
// IDLE  | no miss in flight; hits answered combinationally
// REQ   | memory read request presented, waiting for mem_ready
// WAIT  | request accepted, waiting for mem_rvalid
// RESP  | captured PTE presented with stall=0 for one cycle
module pte_fetch_unit
    import PageStruct::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int ENTRIES    = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] pa,
    input  logic                  flush,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] pte,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [ADDR_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rerr
);

    pte_fetch_state_t      state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] data_q;
    logic                  hit;
    logic [ADDR_WIDTH-1:0] hit_data;

`ifdef PTE_BUF_EN
    logic                  buf_hit;
    logic [ADDR_WIDTH-1:0] buf_data;
    logic                  drop_q;
    logic                  fill_en;

    // A flush coinciding with the return also suppresses the fill.
    assign fill_en = (state_q == WAIT) && mem_rvalid && !mem_rerr &&
                     mem_rdata[PTE_V_BIT] && !drop_q && !flush;

    pte_buffer #(
        .ENTRIES (ENTRIES)
    ) u_pte_buffer (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .lookup_tag (pa[ADDR_WIDTH-1:3]),
        .hit        (buf_hit),
        .hit_data   (buf_data),
        .fill_en    (fill_en),
        .fill_tag   (addr_q[ADDR_WIDTH-1:3]),
        .fill_data  (mem_rdata)
    );

    assign hit      = buf_hit & ~flush;
    assign hit_data = buf_data;
`else
    logic unused_flush;

    assign unused_flush = flush;
    assign hit          = 1'b0;
    assign hit_data     = '0;
`endif

    assign mem_addr = addr_q;

    always_comb begin
        stall = 1'b0;
        pte   = '0;
        unique case (state_q)
            IDLE: begin
                stall = ren & ~hit;
                if (ren && hit) begin
                    pte = hit_data;
                end
            end
            REQ:     stall = 1'b1;
            WAIT:    stall = 1'b1;
            RESP:    pte   = data_q;
            default: stall = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            mem_req <= 1'b0;
`ifdef PTE_BUF_EN
            drop_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ren && !hit) begin
                        addr_q  <= pa;
                        mem_req <= 1'b1;
                        state_q <= REQ;
`ifdef PTE_BUF_EN
                        drop_q  <= 1'b0;
`endif
                    end
                end
                REQ: begin
`ifdef PTE_BUF_EN
                    if (flush) drop_q <= 1'b1;
`endif
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
`ifdef PTE_BUF_EN
                    if (flush) drop_q <= 1'b1;
`endif
                    if (mem_rvalid) begin
                        data_q  <= mem_rerr ? '0 : mem_rdata;
                        state_q <= ren ? RESP : IDLE;
                    end
                end
                RESP: state_q <= IDLE;
                default: begin
                    mem_req <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
